// File: rtl/hex_seg_pkg.sv
// Shared types and constants for the hex display sequencer: FSM states,
// segment constants and the active-high seven-segment glyph table.
package hex_seg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [7:0] SEG_BLANK_AH = 8'h00;
  localparam int         SEG_DP_BIT   = 7;

  // Active-high glyphs, bit0 = a ... bit6 = g; entry 0 is the rightmost element.
  localparam logic [15:0][7:0] GLYPH_AH = {
    8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
    8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble-to-seven-segment decoder with blank and decimal point;
// polarity is selected by ACTIVE_LOW.
module hex_to_seg7
  import hex_seg_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] nibble_i,
  input  logic       blank_i,
  input  logic       dp_i,
  output logic [7:0] seg_o
);

  logic [7:0] seg_ah_s;

  // Blank overrides both glyph and decimal point.
  always_comb begin
    seg_ah_s = SEG_BLANK_AH;
    if (blank_i) begin
      seg_ah_s = SEG_BLANK_AH;
    end else begin
      seg_ah_s             = GLYPH_AH[nibble_i];
      seg_ah_s[SEG_DP_BIT] = dp_i;
    end
    if (ACTIVE_LOW) begin
      seg_o = ~seg_ah_s;
    end else begin
      seg_o = seg_ah_s;
    end
  end

endmodule

// File: rtl/hex_display_sequencer.sv
// Avalon-MM write master that decodes a latched multi-digit hex value and
// writes one seven-segment byte per digit to consecutive HEX PIO slaves.
module hex_display_sequencer
  import hex_seg_pkg::*;
#(
  parameter int          NUM_DIGITS = 6,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [31:0] STRIDE     = 32'h0000_0010,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  output logic                    busy,
  output logic                    done,
  output logic [31:0]             avm_address,
  output logic                    avm_chipselect,
  output logic                    avm_write_n,
  output logic [31:0]             avm_writedata,
  input  logic                    avm_waitrequest
);

  localparam int               IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] value_q, value_d;
  logic [NUM_DIGITS-1:0]   blank_q, blank_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
  logic                    cs_q, cs_d;
  logic                    wn_q, wn_d;
  logic [31:0]             addr_q, addr_d;
  logic [31:0]             data_q, data_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic [IDX_W-1:0] sel_idx_s;
  logic [3:0]       nib_s;
  logic             blk_s;
  logic             dpv_s;
  logic [7:0]       seg_s;

  // idx_q names the beat on the bus; once a beat is on the bus the decoder
  // looks ahead to the next digit so beats can go out back-to-back.
  always_comb begin
    sel_idx_s = idx_q;
    if (cs_q) begin
      sel_idx_s = idx_q + IDX_W'(1);
    end else begin
      sel_idx_s = idx_q;
    end
  end

  // Digit mux feeding the single decoder instance.
  always_comb begin
    nib_s = 4'h0;
    blk_s = 1'b0;
    dpv_s = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sel_idx_s == IDX_W'(i)) begin
        nib_s = value_q[4*i +: 4];
        blk_s = blank_q[i];
        dpv_s = dp_q[i];
      end
    end
  end

  hex_to_seg7 #(
    .ACTIVE_LOW(ACTIVE_LOW)
  ) u_hex_to_seg7 (
    .nibble_i(nib_s),
    .blank_i (blk_s),
    .dp_i    (dpv_s),
    .seg_o   (seg_s)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    value_d = value_q;
    blank_d = blank_q;
    dp_d    = dp_q;
    cs_d    = cs_q;
    wn_d    = wn_q;
    addr_d  = addr_q;
    data_d  = data_q;
    busy_d  = busy_q;
    done_d  = done_q;
    case (state_q)
      IDLE: begin
        done_d = 1'b0;
        if (start) begin
          value_d = value;
          blank_d = blank_mask;
          dp_d    = dp_mask;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = WRITE;
        end else begin
          busy_d = 1'b0;
        end
      end
      WRITE: begin
        if (cs_q && avm_waitrequest) begin
          state_d = WRITE;
        end else if (cs_q && (idx_q == LAST_IDX)) begin
          cs_d    = 1'b0;
          wn_d    = 1'b1;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          idx_d  = sel_idx_s;
          cs_d   = 1'b1;
          wn_d   = 1'b0;
          addr_d = BASE_ADDR + (32'(sel_idx_s) * STRIDE);
          data_d = {24'h00_0000, seg_s};
        end
      end
      DONE: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        cs_d    = 1'b0;
        wn_d    = 1'b1;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State, latched request and registered bus outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      value_q <= '0;
      blank_q <= '0;
      dp_q    <= '0;
      cs_q    <= 1'b0;
      wn_q    <= 1'b1;
      addr_q  <= BASE_ADDR;
      data_q  <= 32'h0000_0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      value_q <= value_d;
      blank_q <= blank_d;
      dp_q    <= dp_d;
      cs_q    <= cs_d;
      wn_q    <= wn_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign avm_address    = addr_q;
  assign avm_chipselect = cs_q;
  assign avm_write_n    = wn_q;
  assign avm_writedata  = data_q;

endmodule
